// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: single-cycle stores and loads that
// stall for one cycle, then present the sign- or zero-extended result.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] addr,
  input  logic        MemRW,
  input  logic [2:0]  RWType,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic [31:0] rd_word_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             illegal;
  logic             load_go;
  logic             store_go;
  logic [3:0]       byte_en;
  logic [31:0]      store_word;
  logic [31:0]      shifted;
  logic [31:0]      fmt_word;
  logic             unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap.
  assign idx         = addr[IDX_W+1:2];
  assign unused_addr = ^addr[31:IDX_W+2];

  // Alignment and encoding legality of the access currently on the inputs.
  always_comb begin
    illegal = 1'b0;
    case (RWType)
      T_B, T_BU: illegal = 1'b0;
      T_H, T_HU: illegal = addr[0];
      T_W:       illegal = |addr[1:0];
      default:   illegal = 1'b1;
    endcase
    if (MemRW && ((RWType == T_BU) || (RWType == T_HU))) begin
      illegal = 1'b1;
    end
  end

  assign fault    = rst_n && req_valid && illegal;
  assign load_go  = rst_n && (state_q == IDLE) && req_valid && !MemRW && !illegal;
  assign store_go = rst_n && (state_q == IDLE) && req_valid && MemRW && !illegal;
  assign stall    = load_go;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    case (RWType)
      T_B: begin
        byte_en    = 4'b0001 << addr[1:0];
        store_word = {4{wdata[7:0]}};
      end
      T_H: begin
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata[15:0]}};
      end
      T_W: begin
        byte_en    = 4'b1111;
        store_word = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = 32'h0;
      end
    endcase
  end

  // Load result formatting from the word fetched in the stall cycle.
  always_comb begin
    shifted  = rd_word_q >> {off_q, 3'b000};
    fmt_word = rd_word_q;
    case (type_q)
      T_B:     fmt_word = {{24{shifted[7]}}, shifted[7:0]};
      T_BU:    fmt_word = {24'h0, shifted[7:0]};
      T_H:     fmt_word = {{16{shifted[15]}}, shifted[15:0]};
      T_HU:    fmt_word = {16'h0, shifted[15:0]};
      default: fmt_word = rd_word_q;
    endcase
  end

  assign rdata = (state_q == RESP) ? fmt_word : rdata_q;

  // Array storage and read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (store_go) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[idx][8*b +: 8] <= store_word[8*b +: 8];
        end
      end
    end
    if (load_go) begin
      rd_word_q <= mem_q[idx];
    end
  end

  // Load-response FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_go) begin
            state_q <= RESP;
            type_q  <= RWType;
            off_q   <= addr[1:0];
          end
        end
        RESP: begin
          rdata_q <= fmt_word;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
